// File: rtl/wwm_btn_pkg.sv
// rtl/wwm_btn_pkg.sv - shared state encoding, default timing constants and counter width helper
package wwm_btn_pkg;

  localparam logic [2:0] ST_INI  = 3'd0;
  localparam logic [2:0] ST_WQ   = 3'd1;
  localparam logic [2:0] ST_SCEN = 3'd2;
  localparam logic [2:0] ST_HELD = 3'd3;
  localparam logic [2:0] ST_WR   = 3'd4;

  localparam int unsigned DBNC_DEFAULT          = 1000000;
  localparam int unsigned REPEAT_DELAY_DEFAULT  = 50000000;
  localparam int unsigned REPEAT_PERIOD_DEFAULT = 10000000;

  // Width that holds 0 .. max_count-1, which is as far as any counter ever runs.
  function automatic int cnt_width(input int unsigned max_count);
    return (max_count <= 2) ? 1 : $clog2(max_count);
  endfunction

endpackage

// File: rtl/wwm_btn_fsm.sv
// rtl/wwm_btn_fsm.sv - one button: 2-FF synchroniser, debounce FSM, optional auto-repeat
// Auto-repeat is built only when WWM_BTN_AUTO_REPEAT_EN is defined.
module wwm_btn_fsm
  import wwm_btn_pkg::*;
#(
  parameter int unsigned DBNC_CYCLES   = DBNC_DEFAULT,
  parameter int unsigned REPEAT_DELAY  = REPEAT_DELAY_DEFAULT,
  parameter int unsigned REPEAT_PERIOD = REPEAT_PERIOD_DEFAULT
) (
  input  logic board_clk,
  input  logic Reset,
  input  logic btn_raw,
  output logic db,
  output logic scen,
  output logic mcen
);

  localparam int CW = cnt_width(DBNC_CYCLES);
  localparam logic [CW-1:0] DB_LAST = CW'(DBNC_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          btn_s;
  logic [2:0]    state;
  logic [CW-1:0] cnt;

  assign btn_s = sync_q[1];

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      sync_q <= 2'b00;
      state  <= ST_INI;
      cnt    <= '0;
    end else begin
      sync_q <= {sync_q[0], btn_raw};
      case (state)
        ST_INI: begin
          cnt <= '0;
          if (btn_s) state <= ST_WQ;
        end
        ST_WQ: begin
          if (!btn_s) begin
            state <= ST_INI;
            cnt   <= '0;
          end else if (cnt == DB_LAST) begin
            state <= ST_SCEN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_SCEN: begin
          state <= ST_HELD;
          cnt   <= '0;
        end
        ST_HELD: begin
          cnt <= '0;
          if (!btn_s) state <= ST_WR;
        end
        ST_WR: begin
          // A short release inside HELD lands here and is absorbed on return.
          if (btn_s) begin
            state <= ST_HELD;
            cnt   <= '0;
          end else if (cnt == DB_LAST) begin
            state <= ST_INI;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_INI;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign db   = (state == ST_SCEN) || (state == ST_HELD) || (state == ST_WR);
  assign scen = (state == ST_SCEN);

`ifdef WWM_BTN_AUTO_REPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = cnt_width(REP_MAX);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] rcnt;
  logic          rphase;
  logic          rep_hit;

  // rphase 0 waits the first delay, 1 runs the steady repeat period.
  assign rep_hit = (state == ST_HELD) && (rcnt == (rphase ? PERIOD_LAST : DELAY_LAST));

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      rcnt   <= '0;
      rphase <= 1'b0;
    end else if (state != ST_HELD) begin
      rcnt   <= '0;
      rphase <= 1'b0;
    end else if (rep_hit) begin
      rcnt   <= '0;
      rphase <= 1'b1;
    end else begin
      rcnt <= rcnt + 1'b1;
    end
  end

  assign mcen = scen | rep_hit;
`else
  assign mcen = scen;
`endif

endmodule

// File: rtl/wwm_btn_conditioner.sv
// rtl/wwm_btn_conditioner.sv - conditions the Start/Fire push-buttons into level, press and repeat enables
// Auto-repeat on btn_mcen is enabled by defining WWM_BTN_AUTO_REPEAT_EN.
module wwm_btn_conditioner
  import wwm_btn_pkg::*;
#(
  parameter int unsigned N_BTN         = 2,
  parameter int unsigned DBNC_CYCLES   = DBNC_DEFAULT,
  parameter int unsigned REPEAT_DELAY  = REPEAT_DELAY_DEFAULT,
  parameter int unsigned REPEAT_PERIOD = REPEAT_PERIOD_DEFAULT
) (
  input  logic             board_clk,
  input  logic             Reset,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_db,
  output logic [N_BTN-1:0] btn_scen,
  output logic [N_BTN-1:0] btn_mcen
);

  for (genvar i = 0; i < int'(N_BTN); i++) begin : g_btn
    wwm_btn_fsm #(
      .DBNC_CYCLES  (DBNC_CYCLES),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_fsm (
      .board_clk(board_clk),
      .Reset    (Reset),
      .btn_raw  (btn_in[i]),
      .db       (btn_db[i]),
      .scen     (btn_scen[i]),
      .mcen     (btn_mcen[i])
    );
  end

endmodule

// File: tb/tb_wwm_btn_conditioner.sv
// tb/tb_wwm_btn_conditioner.sv - directed and randomized checks of wwm_btn_conditioner against a run-length model
// Expected auto-repeat pulses follow WWM_BTN_AUTO_REPEAT_EN.
module tb_wwm_btn_conditioner;

  localparam int DB = 8;
  localparam int RD = 32;
  localparam int RP = 16;
`ifdef WWM_BTN_AUTO_REPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       board_clk = 1'b0;
  logic       Reset;
  logic [1:0] btn_in;
  logic [1:0] btn_db, btn_scen, btn_mcen;

  int tests = 0;
  int fails = 0;

  // Reference: a level is accepted after DB+1 consecutive synchronised samples of
  // the opposite value; the sample taken on the pulse cycle itself is ignored.
  logic [1:0] d1, d2;
  int db_m[2], run_m[2], hk_m[2];
  bit scen_m[2];

  wwm_btn_conditioner #(
    .N_BTN(2), .DBNC_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .board_clk(board_clk),
    .Reset    (Reset),
    .btn_in   (btn_in),
    .btn_db   (btn_db),
    .btn_scen (btn_scen),
    .btn_mcen (btn_mcen)
  );

  always #5 board_clk = ~board_clk;

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    tests++;
    assert (obs == exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    d1 = 2'b00;
    d2 = 2'b00;
    for (int b = 0; b < 2; b++) begin
      db_m[b] = 0; run_m[b] = 0; hk_m[b] = 0; scen_m[b] = 1'b0;
    end
  endtask

  task automatic model_edge(input logic [1:0] vin);
    for (int b = 0; b < 2; b++) begin
      int s;
      s = int'(d2[b]);
      if (scen_m[b]) begin
        scen_m[b] = 1'b0;
        run_m[b]  = 0;
      end else begin
        run_m[b] = (s != db_m[b]) ? run_m[b] + 1 : 0;
        if (run_m[b] == DB + 1) begin
          db_m[b]   = 1 - db_m[b];
          run_m[b]  = 0;
          scen_m[b] = (db_m[b] == 1);
        end
      end
      hk_m[b] = (db_m[b] == 1 && !scen_m[b] && run_m[b] == 0) ? hk_m[b] + 1 : 0;
    end
    d2 = d1;
    d1 = vin;
  endtask

  task automatic check_outputs(input string tag);
    logic [1:0] e_db, e_sc, e_mc;
    for (int b = 0; b < 2; b++) begin
      e_db[b] = (db_m[b] == 1);
      e_sc[b] = scen_m[b];
      e_mc[b] = scen_m[b] | (AR && hk_m[b] >= RD && ((hk_m[b] - RD) % RP) == 0);
    end
    chk({tag, "_db"}, btn_db, e_db);
    chk({tag, "_scen"}, btn_scen, e_sc);
    chk({tag, "_mcen"}, btn_mcen, e_mc);
  endtask

  task automatic step(input logic [1:0] v);
    btn_in = v;
    @(posedge board_clk);
    model_edge(v);
    @(negedge board_clk);
    check_outputs("step");
  endtask

  task automatic reset_cycles(input int n, input logic [1:0] v);
    Reset  = 1'b1;
    btn_in = v;
    #1;
    model_reset();
    check_outputs("reset_async");
    for (int k = 0; k < n; k++) begin
      @(posedge board_clk);
      @(negedge board_clk);
      check_outputs("reset_hold");
    end
    Reset = 1'b0;
  endtask

  task automatic run_until_scen(input logic [1:0] v, input int bi, output int edges);
    edges = 0;
    for (int k = 1; k <= 40; k++) begin
      step(v);
      if (btn_scen[bi]) begin
        edges = k;
        break;
      end
    end
  endtask

  initial begin
    int e, cnt;
    Reset  = 1'b1;
    btn_in = 2'b00;
    model_reset();

    // 1: reset with both buttons high, then a single aligned press
    reset_cycles(5, 2'b11);
    run_until_scen(2'b11, 0, e);
    chk_int("reset_release_latency", e, DB + 3);
    chk("reset_release_both", btn_scen, 2'b11);
    for (int k = 0; k < 5; k++) step(2'b11);
    for (int k = 0; k < 15; k++) step(2'b00);

    // 2: single press, hold, release latency
    run_until_scen(2'b01, 0, e);
    chk_int("press_latency", e, DB + 3);
    for (int k = 0; k < 40; k++) step(2'b01);
    e = 0;
    for (int k = 1; k <= 20; k++) begin
      step(2'b00);
      if (!btn_db[0] && e == 0) e = k;
    end
    chk_int("release_latency", e, DB + 3);

    // 3: bounce on bit1, then hold
    cnt = 0;
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 3; k++) begin
        step((r % 2 == 0) ? 2'b10 : 2'b00);
        if (btn_scen[1]) cnt++;
      end
    chk_int("bounce_no_scen", cnt, 0);
    run_until_scen(2'b10, 1, e);
    chk_int("bounce_latency", e, DB + 3);
    for (int k = 0; k < 5; k++) step(2'b10);
    for (int k = 0; k < 15; k++) step(2'b00);

    // 4: simultaneous press, release glitch while held
    run_until_scen(2'b11, 0, e);
    chk("simul_scen", btn_scen, 2'b11);
    for (int k = 0; k < 15; k++) step(2'b11);
    cnt = 0;
    for (int k = 0; k < 24; k++) begin
      step((k < 4) ? 2'b00 : 2'b11);
      if (btn_scen != 2'b00) cnt++;
      chk("glitch_db_held", btn_db, 2'b11);
    end
    chk_int("glitch_no_second_scen", cnt, 0);
    for (int k = 0; k < 15; k++) step(2'b00);

    // 5: long hold, count mcen pulses including acceptance
    run_until_scen(2'b01, 0, e);
    cnt = btn_mcen[0] ? 1 : 0;
    for (int k = 0; k < 100; k++) begin
      step(2'b01);
      if (btn_mcen[0]) cnt++;
    end
    chk_int("repeat_pulse_count", cnt, AR ? 6 : 1);
    for (int k = 0; k < 15; k++) step(2'b00);

    // 6: reset while waiting in WQ, button stays high
    for (int k = 0; k < 8; k++) step(2'b01);
    reset_cycles(3, 2'b01);
    run_until_scen(2'b01, 0, e);
    chk_int("reset_in_wq_latency", e, DB + 3);
    for (int k = 0; k < 15; k++) step(2'b00);

    // 7: randomized segments checked cycle by cycle against the model
    for (int seg = 0; seg < 120; seg++) begin
      logic [1:0] v;
      int len;
      v   = 2'($urandom_range(0, 3));
      len = $urandom_range(1, 30);
      for (int k = 0; k < len; k++) step(v);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wwm_btn_conditioner.md
Name: wwm_btn_conditioner

Overview:
Input-side conditioner for the push-buttons that feed the game state machine (Start, Fire).
- Synchronises each raw button to board_clk.
- Debounces it with a per-button FSM.
- Emits a level, a single-cycle press pulse, and an optional auto-repeat pulse.
- Sits between the board pins and wwm_sm, so Start/Ack/Fire see exactly one clean pulse per press.

Parameters:
- N_BTN, 2, number of buttons conditioned (bit0 = Start/BtnU, bit1 = Fire/BtnR).
- DBNC_CYCLES, 1000000, cycles a level must be stable to be accepted (10 ms at 100 MHz).
- REPEAT_DELAY, 50000000, held cycles before the first auto-repeat pulse (used only with AUTO_REPEAT_EN).
- REPEAT_PERIOD, 10000000, cycles between later auto-repeat pulses (used only with AUTO_REPEAT_EN).

Ports:
- board_clk  input  1  system clock.
- Reset  input  1  asynchronous, active-high reset.
- btn_in  input  N_BTN  raw, asynchronous button levels, active-high.
- btn_db  output  N_BTN  debounced level.
- btn_scen  output  N_BTN  single-clock enable, one cycle per accepted press.
- btn_mcen  output  N_BTN  multi-clock enable: press pulse plus auto-repeat pulses.

Behaviour:
Reset and clocking:
- Reset is asynchronous, active-high; clock is board_clk.
- While Reset is high: all synchroniser flops 0, every FSM in INI, all counters 0, btn_db = btn_scen = btn_mcen = 0.
- Reset asserted mid-operation (WQ, HELD, WR) aborts at once; no pulse is emitted on release of Reset.

Synchroniser:
- 2-FF synchroniser per bit gives btn_s; 2-cycle latency.

Per-button FSM (Moore; outputs decoded from registered state):
- INI: db=0. btn_s=1 -> WQ with cnt=0.
- WQ: db=0.
  - btn_s=0 -> INI, cnt cleared.
  - btn_s=1 and cnt==DBNC_CYCLES-1 -> SCEN_ST.
  - otherwise cnt++.
- SCEN_ST: exactly one cycle. db=1, scen=1, mcen=1. Then -> HELD with cnt=0.
- HELD: db=1.
  - btn_s=0 -> WR with cnt=0.
  - otherwise stays; the repeat counter runs (see Optional Feature).
- WR: db=1.
  - btn_s=1 -> HELD; repeat counter resets to the first-delay phase.
  - btn_s=0 and cnt==DBNC_CYCLES-1 -> INI.
  - otherwise cnt++.

Latency:
- A clean rising edge on btn_in, held, gives btn_scen high for exactly one cycle.
- That cycle starts DBNC_CYCLES+3 board_clk edges after the input change.
- btn_db falls DBNC_CYCLES+3 edges after a clean release.

Glitches and counters:
- A glitch shorter than DBNC_CYCLES in WQ yields no output.
- A glitch shorter than DBNC_CYCLES in WR is absorbed; btn_db stays 1 and no new scen is issued.
- Counter width is $clog2 of the largest active count + 1; counters never wrap, because comparison stops them.

Channel independence:
- Buttons are fully independent; simultaneous presses give simultaneous pulses on their own bits.

Optional Feature:
Macro: WWM_BTN_AUTO_REPEAT_EN
- Defined: in HELD, a repeat counter pulses mcen for one cycle after REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles while held. Leaving HELD clears the counter.
- Not defined: btn_mcen equals btn_scen, and no repeat counter is synthesised.
- Under both settings btn_scen and btn_db are identical.

Decomposition:
- Package wwm_btn_pkg holds:
  - FSM state encoding (INI, WQ, SCEN_ST, HELD, WR; 3-bit localparams).
  - Default DBNC/REPEAT constants.
  - A width-helper function.
- Sub-module wwm_btn_fsm handles one button: synchroniser, FSM, counters.
- The top generates N_BTN instances of wwm_btn_fsm and concatenates their outputs.

Test Plan (sim parameters: DBNC_CYCLES=8, REPEAT_DELAY=32, REPEAT_PERIOD=16):
1. Reset held 5 cycles, btn_in=2'b11 -> all outputs 0 throughout. After release, btn_scen pulses for exactly 1 cycle, 11 edges later.
2. btn_in[0] rises and holds 40 cycles -> btn_scen[0] high 1 cycle at edge 11; btn_db[0]=1 from edge 11. btn_db falls 11 edges after release.
3. btn_in[1] bounces 1,0,1,0 at 3-cycle intervals, then holds high -> exactly one btn_scen[1] pulse, 11 edges after the final rise. No pulse during the bounce.
4. Both bits rise on the same edge -> both btn_scen bits pulse on the same cycle. A 4-cycle release glitch during HELD -> no second pulse, btn_db stays 1.
5. AUTO_REPEAT_EN defined, btn_in[0] held 100 cycles after acceptance -> btn_mcen[0] pulses at acceptance, +32, +48, +64, +80, +96. Macro undefined -> only the acceptance pulse.
6. Reset asserted while in WQ (cnt=5), then released with the button still high -> FSM restarts from INI; scen occurs a full 11 edges after the Reset release.
